// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready request/response handshakes and flush abort.
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_func,
  input  logic            req_word,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] N_FULL  = CW'(XLEN);
  localparam logic [CW-1:0] N_WORD  = CW'(32);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] F_MUL  = 3'd0;
  localparam logic [2:0] F_DIV  = 3'd1;
  localparam logic [2:0] F_DIVU = 3'd2;
  localparam logic [2:0] F_REM  = 3'd3;
  localparam logic [2:0] F_REMU = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){1'b0}}, v[31:0]};
  endfunction

  state_t          state, state_nx;
  logic [CW-1:0]   counter;
  logic [XLEN-1:0] acc, acc_nx;    // product accumulator / partial remainder
  logic [XLEN-1:0] x, x_nx;        // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] y, y_nx;        // multiplicand / divisor magnitude
  logic [2:0]      func;
  logic            word;
  logic            q_neg, r_neg;

  logic            accept, legal, div_op, signed_op, b_zero, sa, sb;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, special, raw, result;
  logic [XLEN:0]   shifted, diff;

  assign req_ready  = (state == S_IDLE) && !flush;
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign accept     = req_valid && req_ready;

  // Request decode and operand preparation
  always_comb begin
    legal     = (req_func <= F_REMU);
    div_op    = legal && (req_func != F_MUL);
    signed_op = (req_func == F_DIV) || (req_func == F_REM);
    if (req_word) begin
      a_ext = signed_op ? sext32(req_a) : zext32(req_a);
      b_ext = signed_op ? sext32(req_b) : zext32(req_b);
    end else begin
      a_ext = req_a;
      b_ext = req_b;
    end
    sa     = signed_op && a_ext[XLEN-1];
    sb     = signed_op && b_ext[XLEN-1];
    a_mag  = sa ? -a_ext : a_ext;
    b_mag  = sb ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    if (!legal) begin
      special = '0;
    end else if ((req_func == F_DIV) || (req_func == F_DIVU)) begin
      special = '1;
    end else begin
      special = req_word ? sext32(req_a) : req_a;
    end
  end

  // One iteration of the datapath and the finished result
  always_comb begin
    shifted = {acc, x[XLEN-1]};
    diff    = shifted - {1'b0, y};
    acc_nx  = acc;
    x_nx    = x;
    y_nx    = y;
    raw     = '0;
    case (state)
      S_MUL: begin
        acc_nx = x[0] ? acc + y : acc;
        x_nx   = x >> 1;
        y_nx   = y << 1;
        raw    = acc_nx;
      end
      S_DIV: begin
        acc_nx = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        x_nx   = {x[XLEN-2:0], ~diff[XLEN]};
        if ((func == F_DIV) || (func == F_DIVU)) begin
          raw = q_neg ? -x_nx : x_nx;
        end else begin
          raw = r_neg ? -acc_nx : acc_nx;
        end
      end
      default: begin
        raw = '0;
      end
    endcase
    result = word ? sext32(raw) : raw;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (!accept) begin
            state_nx = S_IDLE;
          end else if (!legal || (div_op && b_zero)) begin
            state_nx = S_DONE;
          end else if (req_func == F_MUL) begin
            state_nx = S_MUL;
          end else begin
            state_nx = S_DIV;
          end
        end
        S_MUL, S_DIV: begin
          state_nx = (counter == CNT_ONE) ? S_DONE : state;
        end
        S_DONE: begin
          state_nx = resp_ready ? S_IDLE : S_DONE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      acc       <= '0;
      x         <= '0;
      y         <= '0;
      func      <= 3'd0;
      word      <= 1'b0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      resp_data <= '0;
    end else if (accept) begin
      counter <= req_word ? N_WORD : N_FULL;
      func    <= req_func;
      word    <= req_word;
      q_neg   <= sa ^ sb;
      r_neg   <= sa;
      acc     <= '0;
      if (req_func == F_MUL) begin
        x <= b_ext;
        y <= a_ext;
      end else begin
        // word dividends are pre-aligned so their MSB enters the remainder first
        x <= req_word ? (a_mag << 32) : a_mag;
        y <= b_mag;
      end
      if (!legal || (div_op && b_zero)) resp_data <= special;
    end else if ((state == S_MUL) || (state == S_DIV)) begin
      counter <= counter - CNT_ONE;
      acc     <= acc_nx;
      x       <= x_nx;
      y       <= y_nx;
      if (counter == CNT_ONE) resp_data <= result;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed corner cases plus randomized ops
// checked against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_func;
  logic        req_word;
  logic [63:0] req_a, req_b;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        busy;

  int          checks = 0;
  int          passed = 0;
  logic [63:0] exp_q[$];
  bit          rr_random = 1'b1;
  bit          rr_val = 1'b1;

  always #5 clk = ~clk;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_op(input int f, input bit w, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    case (f)
      0: begin
        r32 = a32 * b32;
        r64 = a * b;
        return w ? sx(r32) : r64;
      end
      1: begin
        if (w) begin
          if (b32 == 32'd0) return '1;
          if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx(32'h8000_0000);
          r32 = $signed(a32) / $signed(b32);
          return sx(r32);
        end
        if (b == 64'd0) return '1;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
        r64 = $signed(a) / $signed(b);
        return r64;
      end
      2: begin
        if (w) begin
          if (b32 == 32'd0) return '1;
          r32 = a32 / b32;
          return sx(r32);
        end
        return (b == 64'd0) ? '1 : a / b;
      end
      3: begin
        if (w) begin
          if (b32 == 32'd0) return sx(a32);
          if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 64'd0;
          r32 = $signed(a32) % $signed(b32);
          return sx(r32);
        end
        if (b == 64'd0) return a;
        if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
        r64 = $signed(a) % $signed(b);
        return r64;
      end
      4: begin
        if (w) begin
          if (b32 == 32'd0) return sx(a32);
          r32 = a32 % b32;
          return sx(r32);
        end
        return (b == 64'd0) ? a : a % b;
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int ref_lat(input int f, input bit w, input logic [63:0] b);
    if (f > 4) return 1;
    if (f != 0 && (w ? (b[31:0] == 32'd0) : (b == 64'd0))) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'($urandom_range(0, 20));
      2: return -64'($urandom_range(1, 20));
      3: return 64'h8000_0000_0000_0000;
      4: return '1;
      5: return {32'($urandom), 32'h8000_0000};
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      checks++;
      $display("FAIL req_ready_timeout: still busy after %0d cycles", n);
    end
  endtask

  // Issue one op, push its expected result, and check busy and latency
  task automatic do_op(input int f, input bit w, input logic [63:0] a, input logic [63:0] b);
    int n;
    bit ok;
    wait_idle(ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_func  = 3'(f);
    req_word  = w;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    exp_q.push_back(ref_op(f, w, a, b));
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", 64'(busy), 64'd1);
    end while (!resp_valid && n < 200);
    check("latency", 64'(n), 64'(ref_lat(f, w, b)));
  endtask

  // Consumer: random backpressure unless the main sequence pins it
  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2 resp_ready = rr_random ? ($urandom_range(0, 3) != 0) : rr_val;
    end
  end

  // Monitor: compare every completed response handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid && resp_ready && !flush && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_resp: got %h with no pending op", resp_data);
        end else begin
          check("resp_data", resp_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int bad;
    bit ok;
    reset = 1'b1; req_valid = 1'b0; req_func = 3'd0; req_word = 1'b0;
    req_a = 64'd0; req_b = 64'd0; flush = 1'b0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(0, 1'b0, 64'd6, 64'd7);
    do_op(0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    do_op(1, 1'b0, -64'd7, 64'd2);
    do_op(3, 1'b0, -64'd7, 64'd2);
    do_op(4, 1'b0, 64'd7, 64'd2);
    do_op(2, 1'b0, 64'd5, 64'd0);
    do_op(3, 1'b0, 64'd5, 64'd0);
    do_op(1, 1'b0, 64'h8000_0000_0000_0000, '1);
    do_op(3, 1'b0, 64'h8000_0000_0000_0000, '1);
    do_op(6, 1'b0, 64'd9, 64'd3);
    do_op(1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF);

    // Response held under backpressure, then released
    rr_random = 1'b0; rr_val = 1'b0;
    @(posedge clk); #3;
    do_op(0, 1'b0, 64'd13, 64'd11);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_data", resp_data, 64'd143);
    end
    rr_val = 1'b1;
    @(posedge clk); #3;
    @(negedge clk);
    @(negedge clk);
    check("release_req_ready", 64'(req_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);
    rr_random = 1'b1;

    // Flush in the middle of a divide
    wait_idle(ok);
    req_valid = 1'b1; req_func = 3'd1; req_word = 1'b0; req_a = 64'd1000; req_b = 64'd7;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid) bad++;
    end
    check("flush_no_resp", 64'(bad), 64'd0);

    // Flush and request together in IDLE
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_func = 3'd0; req_a = 64'd2; req_b = 64'd2;
    #1 check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    check("flush_not_accepted", 64'(busy), 64'd0);

    // Asynchronous reset during a multiply
    wait_idle(ok);
    req_valid = 1'b1; req_func = 3'd0; req_word = 1'b0; req_a = 64'h1234; req_b = 64'h5678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_resp_data", resp_data, 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op(0, 1'b0, 64'd3, 64'd3);

    for (int i = 0; i < 60; i++) begin
      do_op(($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
            1'($urandom_range(0, 1)), pick(), pick());
    end

    bad = 0;
    while (exp_q.size() != 0 && bad < 500) begin
      @(negedge clk);
      bad++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
